// File: rtl/bbc_loader_pkg.sv
// rtl/bbc_loader_pkg.sv - shared constants and FIFO entry type for the ROM loader
`timescale 1ns/1ps
package bbc_loader_pkg;

  localparam logic [24:0] ROM_BASE_DEF   = 25'h80000;
  localparam logic [24:0] ALT_BASE_DEF   = 25'h68000;
  localparam logic [7:0]  CMOS_INDEX_DEF = 8'hFF;

  typedef struct packed {
    logic [24:0] addr;
    logic [7:0]  data;
  } loader_entry_t;

endpackage

// File: rtl/loader_fifo.sv
// rtl/loader_fifo.sv - single-clock FIFO of SDRAM write entries
`timescale 1ns/1ps
module loader_fifo
  import bbc_loader_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic          clk_48m,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  loader_entry_t din,
  output loader_entry_t dout,
  output logic          empty,
  output logic          full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  loader_entry_t mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          do_push;
  logic          do_pop;

  // Status from pointer comparison; a full FIFO still accepts a push when a pop frees the head slot.
  always_comb begin
    empty   = (wr_ptr == rd_ptr);
    full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    dout    = mem[rd_ptr[AW-1:0]];
  end

  // Storage write; the head slot is read before it can be overwritten in a full push+pop cycle.
  always_ff @(posedge clk_48m) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= din;
    end
  end

  // Pointer update; reset flushes every queued entry.
  always_ff @(posedge clk_48m) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

endmodule

// File: rtl/bbc_rom_loader.sv
// rtl/bbc_rom_loader.sv - buffers data_io download bytes and replays them into SDRAM slots
`timescale 1ns/1ps
module bbc_rom_loader
  import bbc_loader_pkg::*;
#(
  parameter int          DEPTH      = 4,
  parameter logic [24:0] ROM_BASE   = ROM_BASE_DEF,
  parameter logic [24:0] ALT_BASE   = ALT_BASE_DEF,
  parameter logic [7:0]  CMOS_INDEX = CMOS_INDEX_DEF
) (
  input  logic        clk_48m,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [7:0]  ioctl_index,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic        mem_sync,
  output logic        loader_active,
  output logic        loader_we,
  output logic [24:0] loader_addr,
  output logic [7:0]  loader_data,
  output logic        cmos_we,
  output logic [6:0]  cmos_addr,
  output logic [7:0]  cmos_data,
  output logic        overflow
);

  logic          accept;
  logic          is_cmos;
  logic          push;
  logic          pop;
  logic [24:0]   base;
  loader_entry_t din;
  loader_entry_t head;
  logic          empty;
  logic          full;
  logic          download_q;

  // Index decode and base translation; the 25-bit add wraps by construction.
  always_comb begin
    accept   = ioctl_wr && ioctl_download;
    is_cmos  = (ioctl_index == CMOS_INDEX);
    push     = accept && !is_cmos;
    pop      = mem_sync && !empty;
    base     = (ioctl_index == 8'h00) ? ROM_BASE : ALT_BASE;
    din.addr = ioctl_addr + base;
    din.data = ioctl_dout;
  end

  loader_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_48m (clk_48m),
    .reset   (reset),
    .push    (push),
    .pop     (pop),
    .din     (din),
    .dout    (head),
    .empty   (empty),
    .full    (full)
  );

  // CMOS bytes bypass the FIFO and appear as a single-cycle write strobe.
  always_ff @(posedge clk_48m) begin
    if (reset) begin
      cmos_we   <= 1'b0;
      cmos_addr <= '0;
      cmos_data <= '0;
    end else begin
      cmos_we <= accept && is_cmos;
      if (accept && is_cmos) begin
        cmos_addr <= ioctl_addr[6:0];
        cmos_data <= ioctl_dout;
      end
    end
  end

  // Slot drain: write enable and address/data only change on a mem_sync, so each write spans one slot.
  always_ff @(posedge clk_48m) begin
    if (reset) begin
      loader_we   <= 1'b0;
      loader_addr <= '0;
      loader_data <= '0;
    end else if (mem_sync) begin
      loader_we <= !empty;
      if (!empty) begin
        loader_addr <= head.addr;
        loader_data <= head.data;
      end
    end
  end

  // Port ownership and sticky drop flag; a new download start clears the flag.
  always_ff @(posedge clk_48m) begin
    if (reset) begin
      loader_active <= 1'b0;
      overflow      <= 1'b0;
      download_q    <= 1'b0;
    end else begin
      loader_active <= ioctl_download || !empty || loader_we;
      download_q    <= ioctl_download;
      if (ioctl_download && !download_q) begin
        overflow <= 1'b0;
      end
      if (push && full && !pop) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bbc_rom_loader.sv
// tb/tb_bbc_rom_loader.sv - scoreboard bench for bbc_rom_loader
`timescale 1ns/1ps
module tb_bbc_rom_loader;

  logic        clk_48m = 1'b0;
  logic        reset = 1'b1;
  logic        ioctl_download = 1'b0;
  logic        ioctl_wr = 1'b0;
  logic [7:0]  ioctl_index = '0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic        mem_sync = 1'b0;
  logic        loader_active;
  logic        loader_we;
  logic [24:0] loader_addr;
  logic [7:0]  loader_data;
  logic        cmos_we;
  logic [6:0]  cmos_addr;
  logic [7:0]  cmos_data;
  logic        overflow;

  bbc_rom_loader #(.DEPTH(4)) dut (
    .clk_48m        (clk_48m),
    .reset          (reset),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_index    (ioctl_index),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .mem_sync       (mem_sync),
    .loader_active  (loader_active),
    .loader_we      (loader_we),
    .loader_addr    (loader_addr),
    .loader_data    (loader_data),
    .cmos_we        (cmos_we),
    .cmos_addr      (cmos_addr),
    .cmos_data      (cmos_data),
    .overflow       (overflow)
  );

  always #5 clk_48m = ~clk_48m;

  typedef struct {
    logic [24:0] addr;
    logic [7:0]  data;
  } mem_exp_t;

  typedef struct {
    logic [6:0] addr;
    logic [7:0] data;
    int         due;
  } cmos_exp_t;

  mem_exp_t  mem_q[$];
  cmos_exp_t cmos_q[$];
  int        checks = 0;
  int        errors = 0;
  int        cyc = 0;
  logic      ms_q = 1'b0;
  logic      rst_q = 1'b1;
  logic      we_prev = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got unexpected event expected none", name);
  endtask

  function automatic logic [63:0] all_outputs();
    return 64'({loader_active, loader_we, loader_addr, loader_data,
                cmos_we, cmos_addr, cmos_data, overflow});
  endfunction

  always @(posedge clk_48m) begin
    ms_q  <= mem_sync;
    rst_q <= reset;
    cyc   <= cyc + 1;
  end

  always @(negedge clk_48m) begin
    mem_exp_t  m;
    cmos_exp_t c;
    if (!rst_q) begin
      if (!ms_q && (loader_we !== we_prev)) flag("we_changed_outside_slot");
      if (ms_q && loader_we) begin
        if (mem_q.size() == 0) flag("sdram_write");
        else begin
          m = mem_q.pop_front();
          check("loader_addr", 64'(loader_addr), 64'(m.addr));
          check("loader_data", 64'(loader_data), 64'(m.data));
        end
      end
      if (cmos_we) begin
        if (cmos_q.size() == 0) flag("cmos_write");
        else begin
          c = cmos_q.pop_front();
          check("cmos_addr", 64'(cmos_addr), 64'(c.addr));
          check("cmos_data", 64'(cmos_data), 64'(c.data));
          check("cmos_latency", 64'(cyc), 64'(c.due));
        end
      end
    end
    we_prev = loader_we;
  end

  task automatic tick();
    @(posedge clk_48m);
    #1;
  endtask

  task automatic sample();
    @(negedge clk_48m);
  endtask

  task automatic wr_byte(input logic [7:0] idx, input logic [24:0] a, input logic [7:0] d,
                         input logic [24:0] exp_addr, input bit expect_it);
    cmos_exp_t c;
    mem_exp_t  m;
    ioctl_wr    = 1'b1;
    ioctl_index = idx;
    ioctl_addr  = a;
    ioctl_dout  = d;
    if (expect_it) begin
      if (idx == 8'hFF) begin
        c.addr = a[6:0];
        c.data = d;
        c.due  = cyc + 1;
        cmos_q.push_back(c);
      end else begin
        m.addr = exp_addr;
        m.data = d;
        mem_q.push_back(m);
      end
    end
    tick();
  endtask

  task automatic sync();
    mem_sync = 1'b1;
    tick();
    mem_sync = 1'b0;
  endtask

  task automatic slots(input int n);
    repeat (n) begin
      repeat (31) tick();
      sync();
    end
  endtask

  task automatic dl_restart();
    ioctl_download = 1'b0;
    tick();
    ioctl_download = 1'b1;
    tick();
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    repeat (3) tick();
    sample();
    check("reset_outputs", all_outputs(), 64'h0);
    tick();
    reset = 1'b0;
    ioctl_download = 1'b1;
    tick();

    // Single ROM byte
    wr_byte(8'h00, 25'h0000, 8'hA5, 25'h80000, 1'b1);
    ioctl_wr = 1'b0;
    ioctl_download = 1'b0;
    tick();
    tick();
    sync();
    sample();
    check("rom_we_high", 64'(loader_we), 64'h1);
    slots(1);
    sample();
    check("rom_we_slot_end", 64'(loader_we), 64'h0);
    check("active_during_last_slot_end", 64'(loader_active), 64'h1);
    tick();
    sample();
    check("active_falls", 64'(loader_active), 64'h0);

    // Alternate index
    dl_restart();
    wr_byte(8'h40, 25'h1234, 8'h5A, 25'h69234, 1'b1);
    ioctl_wr = 1'b0;
    ioctl_download = 1'b0;
    tick();
    sync();
    slots(1);
    tick();

    // CMOS path
    dl_restart();
    wr_byte(8'hFF, 25'h007F, 8'h3C, 25'h0, 1'b1);
    ioctl_wr = 1'b0;
    tick();
    sync();
    sample();
    check("cmos_no_sdram_write", 64'(loader_we), 64'h0);

    // Burst of four, drained one per slot
    tick();
    wr_byte(8'h00, 25'h0010, 8'h11, 25'h80010, 1'b1);
    wr_byte(8'h00, 25'h0011, 8'h22, 25'h80011, 1'b1);
    wr_byte(8'h00, 25'h0012, 8'h33, 25'h80012, 1'b1);
    wr_byte(8'h00, 25'h0013, 8'h44, 25'h80013, 1'b1);
    ioctl_wr = 1'b0;
    slots(5);
    sample();
    check("burst_no_overflow", 64'(overflow), 64'h0);
    check("burst_drained", 64'(mem_q.size()), 64'h0);

    // Overflow: one slot frees an entry, 5th fills, 6th drops
    tick();
    wr_byte(8'h00, 25'h0100, 8'h01, 25'h80100, 1'b1);
    wr_byte(8'h00, 25'h0101, 8'h02, 25'h80101, 1'b1);
    wr_byte(8'h00, 25'h0102, 8'h03, 25'h80102, 1'b1);
    wr_byte(8'h00, 25'h0103, 8'h04, 25'h80103, 1'b1);
    ioctl_wr = 1'b0;
    sync();
    wr_byte(8'h00, 25'h0104, 8'h05, 25'h80104, 1'b1);
    wr_byte(8'h00, 25'h0105, 8'h06, 25'h80105, 1'b0);
    ioctl_wr = 1'b0;
    tick();
    sample();
    check("overflow_set", 64'(overflow), 64'h1);
    slots(5);
    sample();
    check("overflow_sticky", 64'(overflow), 64'h1);
    tick();
    dl_restart();
    sample();
    check("overflow_cleared", 64'(overflow), 64'h0);

    // Simultaneous push and pop with a full FIFO
    tick();
    wr_byte(8'h01, 25'h0020, 8'hC0, 25'h68020, 1'b1);
    wr_byte(8'h01, 25'h0021, 8'hC1, 25'h68021, 1'b1);
    wr_byte(8'h01, 25'h0022, 8'hC2, 25'h68022, 1'b1);
    wr_byte(8'h01, 25'h0023, 8'hC3, 25'h68023, 1'b1);
    mem_sync = 1'b1;
    wr_byte(8'h01, 25'h0024, 8'hC4, 25'h68024, 1'b1);
    mem_sync = 1'b0;
    ioctl_wr = 1'b0;
    tick();
    sample();
    check("simul_no_overflow", 64'(overflow), 64'h0);
    tick();
    wr_byte(8'h01, 25'h0025, 8'hC5, 25'h68025, 1'b0);
    ioctl_wr = 1'b0;
    tick();
    sample();
    check("simul_count_unchanged_full", 64'(overflow), 64'h1);
    tick();
    slots(5);
    sample();
    check("simul_drained", 64'(mem_q.size()), 64'h0);

    // Mid-operation reset with three bytes queued
    tick();
    dl_restart();
    wr_byte(8'h00, 25'h0200, 8'hD0, 25'h80200, 1'b1);
    wr_byte(8'h00, 25'h0201, 8'hD1, 25'h80201, 1'b0);
    wr_byte(8'h00, 25'h0202, 8'hD2, 25'h80202, 1'b0);
    wr_byte(8'h00, 25'h0203, 8'hD3, 25'h80203, 1'b0);
    ioctl_wr = 1'b0;
    sync();
    sample();
    check("pre_reset_we", 64'(loader_we), 64'h1);
    tick();
    reset = 1'b1;
    ioctl_download = 1'b0;
    tick();
    sample();
    check("mid_reset_outputs", all_outputs(), 64'h0);
    tick();
    reset = 1'b0;
    tick();
    sync();
    sample();
    check("post_reset_no_write", 64'(loader_we), 64'h0);
    check("post_reset_inactive", 64'(loader_active), 64'h0);
    slots(1);
    sample();
    check("post_reset_still_no_write", 64'(loader_we), 64'h0);
    check("sdram_queue_empty", 64'(mem_q.size()), 64'h0);
    check("cmos_queue_empty", 64'(cmos_q.size()), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
